// File: rtl/controller_pkg.sv
// Shared types and constants for the serial game-controller poller.
package controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    SHIFT_HI,
    SHIFT_LO,
    DONE
  } state_t;

  localparam int BITS_PER_CTRL = 8;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/controller_reader_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/controller_reader.sv
// Polls NUM_CTRL serial controllers sharing latch/clock lines and publishes
// active-high button words once per poll.
module controller_reader
  import controller_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int NUM_CTRL    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            ctrl_latch,
  output logic                            ctrl_clk,
  input  logic [NUM_CTRL-1:0]             ctrl_data_B,
  output logic [BITS_PER_CTRL*NUM_CTRL-1:0] buttons,
  output logic                            valid,
  output logic                            busy
);

  localparam int CNT_W = $clog2(2 * HALF_PERIOD);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [2:0]       LAST_BIT   = 3'(BITS_PER_CTRL - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [NUM_CTRL-1:0] data_sync;

  logic timed;
  logic phase_last;
  logic sample_en;
  logic final_sample;

  sync_2ff #(
    .WIDTH     (NUM_CTRL),
    .RESET_VAL ({NUM_CTRL{1'b1}})
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ctrl_data_B),
    .q     (data_sync)
  );

  always_comb begin
    timed        = (state_reg == LATCH) || (state_reg == GAP) ||
                   (state_reg == SHIFT_HI) || (state_reg == SHIFT_LO);
    phase_last   = (state_reg == LATCH) ? (cnt_reg == LATCH_LAST)
                                        : (cnt_reg == HALF_LAST);
    // Bit 7 is taken at the end of the gap, bits 6..0 at the end of each low phase.
    sample_en    = phase_last && ((state_reg == GAP) || (state_reg == SHIFT_LO));
    final_sample = phase_last && (state_reg == SHIFT_LO) && (bit_cnt_reg == LAST_BIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (timed && !phase_last) cnt_reg <= cnt_reg + 1'b1;
      else                      cnt_reg <= '0;
      if (sample_en)
        bit_cnt_reg <= (state_reg == GAP) ? 3'd1 : bit_cnt_reg + 3'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:     if (start)      state_next = LATCH;
      LATCH:    if (phase_last) state_next = GAP;
      GAP:      if (phase_last) state_next = SHIFT_HI;
      SHIFT_HI: if (phase_last) state_next = SHIFT_LO;
      SHIFT_LO: if (phase_last) state_next = (bit_cnt_reg == LAST_BIT) ? DONE : SHIFT_HI;
      DONE:                     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    ctrl_latch = (state_reg == LATCH);
    ctrl_clk   = (state_reg == SHIFT_HI);
    valid      = (state_reg == DONE);
    busy       = timed;
  end

  // Each controller has its own data path; timing is shared.
  generate
    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
      logic [BITS_PER_CTRL-1:0] shift_reg;
      logic [BITS_PER_CTRL-1:0] btn_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shift_reg <= '0;
          btn_reg   <= '0;
        end else begin
          if (sample_en)
            shift_reg <= {shift_reg[BITS_PER_CTRL-2:0], data_sync[gi]};
          // Written on the edge entering DONE so the word is new exactly while valid is high.
          if (final_sample)
            btn_reg <= ~{shift_reg[BITS_PER_CTRL-2:0], data_sync[gi]};
        end
      end

      assign buttons[BITS_PER_CTRL*gi +: BITS_PER_CTRL] = btn_reg;
    end
  endgenerate

endmodule

// File: tb/tb_controller_reader.sv
// Randomized self-checking bench for controller_reader with behavioural controller models.
module tb_controller_reader;

  localparam int H   = 4;
  localparam int N   = 2;
  localparam int LAT = 17 * H + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            ctrl_latch, ctrl_clk, valid, busy;
  logic [N-1:0]    ctrl_data_B;
  logic [8*N-1:0]  buttons;

  logic [7:0]   press [N];
  logic [N-1:0] discon = '0;
  logic [7:0]   model_sr [N];
  logic         prev_cclk = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int latch_hi = 0, latch_rise = 0, cclk_rise = 0, valid_cnt = 0, busy_cnt = 0;
  logic latch_q = 1'b0, cclk_q = 1'b0;

  always #5 clk = ~clk;

  controller_reader #(.HALF_PERIOD(H), .NUM_CTRL(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ctrl_latch  (ctrl_latch),
    .ctrl_clk    (ctrl_clk),
    .ctrl_data_B (ctrl_data_B),
    .buttons     (buttons),
    .valid       (valid),
    .busy        (busy)
  );

  // Controller model: parallel-load while latched, shift on ctrl_clk rise, data = MSB, active low.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_model
      assign ctrl_data_B[gi] = discon[gi] ? 1'b1 : model_sr[gi][7];
    end
  endgenerate

  always @(posedge clk) begin
    prev_cclk <= ctrl_clk;
    for (int i = 0; i < N; i++) begin
      if (ctrl_latch)                  model_sr[i] <= ~press[i];
      else if (ctrl_clk && !prev_cclk) model_sr[i] <= {model_sr[i][6:0], 1'b1};
    end
  end

  always @(negedge clk) begin
    latch_q <= ctrl_latch;
    cclk_q  <= ctrl_clk;
    if (ctrl_latch) latch_hi <= latch_hi + 1;
    if (ctrl_latch && !latch_q) latch_rise <= latch_rise + 1;
    if (ctrl_clk && !cclk_q) cclk_rise <= cclk_rise + 1;
    if (valid) valid_cnt <= valid_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  function automatic logic [8*N-1:0] expected_word();
    logic [8*N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[8*i +: 8] = discon[i] ? 8'h00 : press[i];
    return w;
  endfunction

  // Pulses start, returns the cycle at which valid was seen (-1 if never), then idles one cycle.
  task automatic poll(output int lat);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (valid) begin
        lat = c;
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int l0, c0, v0, b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({ctrl_latch, ctrl_clk, valid, busy} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b expected 0000", {ctrl_latch, ctrl_clk, valid, busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    l0 = latch_hi; c0 = cclk_rise; v0 = valid_cnt; b0 = busy_cnt;
    repeat (100) @(negedge clk);
    @(negedge clk);
    compared++;
    if ((latch_hi - l0) + (cclk_rise - c0) + (valid_cnt - v0) + (busy_cnt - b0) !== 0) begin
      mismatched++;
      $display("FAIL idle_activity: latch %0d clk %0d valid %0d busy %0d expected all 0",
               latch_hi - l0, cclk_rise - c0, valid_cnt - v0, busy_cnt - b0);
    end
    compared++;
    if (buttons !== 16'h0000) begin
      mismatched++;
      $display("FAIL idle_buttons: got %h expected 0000", buttons);
    end
    $display("reset: idle 100 cycles, buttons=%h", buttons);
  endtask

  task automatic test_basic_poll();
    int lat, l0, lr0, c0, v0, b0;
    press[0] = 8'h81;
    press[1] = 8'h28;
    l0 = latch_hi; lr0 = latch_rise; c0 = cclk_rise; v0 = valid_cnt; b0 = busy_cnt;
    poll(lat);
    compared++;
    if (lat !== LAT) begin
      mismatched++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
    end
    compared++;
    if (buttons !== 16'h2881) begin
      mismatched++;
      $display("FAIL basic_buttons: got %h expected 2881", buttons);
    end
    compared++;
    if (latch_rise - lr0 !== 1 || latch_hi - l0 !== 2 * H) begin
      mismatched++;
      $display("FAIL basic_latch: got %0d pulses %0d cycles expected 1 pulse %0d cycles",
               latch_rise - lr0, latch_hi - l0, 2 * H);
    end
    compared++;
    if (cclk_rise - c0 !== 7) begin
      mismatched++;
      $display("FAIL basic_clk_edges: got %0d expected 7", cclk_rise - c0);
    end
    compared++;
    if (valid_cnt - v0 !== 1 || busy_cnt - b0 !== LAT - 1) begin
      mismatched++;
      $display("FAIL basic_valid_busy: got valid %0d busy %0d expected 1 and %0d",
               valid_cnt - v0, busy_cnt - b0, LAT - 1);
    end
    $display("basic poll: lat=%0d buttons=%h", lat, buttons);
  endtask

  task automatic test_random_polls();
    int lat;
    logic [8*N-1:0] prev;
    for (int k = 0; k < 8; k++) begin
      prev = expected_word();
      compared++;
      if (buttons !== prev) begin
        mismatched++;
        $display("FAIL rand_hold[%0d]: got %h expected %h", k, buttons, prev);
      end
      for (int i = 0; i < N; i++) press[i] = 8'($urandom);
      poll(lat);
      compared++;
      if (lat !== LAT || buttons !== expected_word()) begin
        mismatched++;
        $display("FAIL rand_poll[%0d]: got lat %0d buttons %h expected lat %0d buttons %h",
                 k, lat, buttons, LAT, expected_word());
      end
      $display("random poll %0d: buttons=%h", k, buttons);
    end
  endtask

  task automatic test_disconnected();
    int lat;
    press[0] = 8'($urandom) | 8'h01;
    press[1] = 8'($urandom) | 8'h80;
    poll(lat);
    compared++;
    if (buttons !== expected_word()) begin
      mismatched++;
      $display("FAIL discon_pre: got %h expected %h", buttons, expected_word());
    end
    discon = '1;
    poll(lat);
    compared++;
    if (lat !== LAT || buttons !== 16'h0000) begin
      mismatched++;
      $display("FAIL discon_zero: got lat %0d buttons %h expected lat %0d buttons 0000",
               lat, buttons, LAT);
    end
    discon = '0;
    $display("disconnected poll: buttons=%h", buttons);
  endtask

  task automatic test_ignored_start();
    int vcyc [$];
    for (int i = 0; i < N; i++) press[i] = 8'($urandom);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 2 * LAT + 10; c++) begin
      @(negedge clk);
      if (valid) vcyc.push_back(c);
      start = (c == 10 || c == 40 || c == LAT || c == LAT + 1);
    end
    start = 1'b0;
    compared++;
    if (vcyc.size() !== 2) begin
      mismatched++;
      $display("FAIL ignore_count: got %0d valid pulses expected 2", vcyc.size());
    end else begin
      compared++;
      if (vcyc[0] !== LAT || vcyc[1] !== 2 * LAT + 1) begin
        mismatched++;
        $display("FAIL ignore_timing: got %0d,%0d expected %0d,%0d",
                 vcyc[0], vcyc[1], LAT, 2 * LAT + 1);
      end
    end
    compared++;
    if (buttons !== expected_word()) begin
      mismatched++;
      $display("FAIL ignore_buttons: got %h expected %h", buttons, expected_word());
    end
    $display("ignored start: %0d valid pulses, buttons=%h", vcyc.size(), buttons);
  endtask

  task automatic test_reset_mid_poll();
    int lat, v0, b0;
    press[0] = 8'hA5;
    press[1] = 8'h3C;
    poll(lat);
    for (int i = 0; i < N; i++) press[i] = 8'($urandom);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c < 30; c++) @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    compared++;
    if ({ctrl_latch, ctrl_clk, valid, busy} !== 4'b0000 || buttons !== 16'h0000) begin
      mismatched++;
      $display("FAIL midreset_outputs: got ctl %b buttons %h expected 0000 and 0000",
               {ctrl_latch, ctrl_clk, valid, busy}, buttons);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cnt; b0 = busy_cnt;
    repeat (150) @(negedge clk);
    compared++;
    if (valid_cnt - v0 !== 0 || busy_cnt - b0 !== 0) begin
      mismatched++;
      $display("FAIL midreset_quiet: got valid %0d busy %0d expected 0 0",
               valid_cnt - v0, busy_cnt - b0);
    end
    poll(lat);
    compared++;
    if (lat !== LAT || buttons !== expected_word()) begin
      mismatched++;
      $display("FAIL midreset_repoll: got lat %0d buttons %h expected lat %0d buttons %h",
               lat, buttons, LAT, expected_word());
    end
    $display("mid-poll reset then poll: buttons=%h", buttons);
  endtask

  task automatic test_change_after_latch();
    logic [8*N-1:0] captured;
    int lat;
    for (int i = 0; i < N; i++) press[i] = 8'($urandom);
    captured = expected_word();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 2 * H + 1)
        for (int i = 0; i < N; i++) press[i] = ~press[i];
      if (valid) begin
        lat = c;
        break;
      end
    end
    compared++;
    if (lat !== LAT || buttons !== captured) begin
      mismatched++;
      $display("FAIL latch_capture: got lat %0d buttons %h expected lat %0d buttons %h",
               lat, buttons, LAT, captured);
    end
    $display("change after latch: buttons=%h", buttons);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    press[0] = 8'h00;
    press[1] = 8'h00;
    test_reset();
    test_basic_poll();
    test_random_polls();
    test_disconnected();
    test_ignored_start();
    test_reset_mid_poll();
    test_change_after_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
